pc_update_unit: RTL and testbench
=================================

// Module: pc_update_unit
// PURPOSE
//   Program-counter stage consuming the branch-decision bit (ZERO & BRANCH) and the jump flag.
//   Holds the PC, computes PC+4 and the PC-relative target, and stalls while either cache asserts busywait.
//   Keeps any redirect that resolves during a stall, flags a flush to fetch/decode, and counts stall cycles.
//   Sits between the branch-decision gate/control unit and the instruction cache address port.
// PARAMETERS
//   PC_W      32  width of PC and target arithmetic
//   OFF_W     8   width of signed branch/jump offset (in instructions)
//   RESET_PC  0   PC value loaded on reset
//   CNT_W     16  width of saturating stall-cycle counter
// PORTS
//   CLK           in   1        single clock, all state updates on rising edge
//   RESET         in   1        synchronous, active-high; sampled on CLK rising edge
//   BRANCH_TAKEN  in   1        branch condition met (from branch-decision gate)
//   JUMP          in   1        unconditional jump from control unit
//   OFFSET        in   OFF_W    signed offset, instruction-relative
//   BUSYWAIT_I    in   1        instruction cache busy
//   BUSYWAIT_D    in   1        data cache busy
//   PC            out  PC_W     current fetch address
//   PC_PLUS4      out  PC_W     PC+4, combinational from PC
//   FLUSH         out  1        one-cycle pulse: redirect applied this edge, discard fetched instr
//   STALL_CNT     out  CNT_W    stall cycles since reset, saturating
// BEHAVIOUR
//   Reset values: PC=RESET_PC, FLUSH=0, STALL_CNT=0, state=RUN, pend_target=0. RESET beats all other inputs.
//   redirect = BRANCH_TAKEN | JUMP.
//   target = PC_PLUS4 + (sext(OFFSET) << 2), taken modulo 2^PC_W. Wrap-around is silent.
//   stall = BUSYWAIT_I | BUSYWAIT_D.
//   FSM, with one rising edge per transition:
//     RUN: if stall & redirect  -> latch pend_target=target, PC held, go STALL_PEND
//          elif stall           -> PC held, go STALL
//          elif redirect        -> PC=target, FLUSH=1, stay RUN
//          else                 -> PC=PC+4, stay RUN
//     STALL: redirect is ignored here (the instruction is frozen in decode).
//          if stall             -> hold
//          else                 -> PC=PC+4, go RUN
//     STALL_PEND: BRANCH_TAKEN, JUMP and OFFSET are ignored. The latched target is final.
//          if stall             -> hold
//          else                 -> PC=pend_target, FLUSH=1, go RUN
//   FLUSH is registered: high for exactly the one cycle after the edge that loads a target, otherwise 0.
//   STALL_CNT increments on each edge where stall=1 in any state and holds at 2^CNT_W-1.
//   Latency: a redirect seen in RUN without a stall appears on PC one cycle later.
//   PC_PLUS4 has zero latency.
//   Reset mid-stall or in STALL_PEND discards pend_target. No redirect survives reset.
//   Redirect in RUN with OFFSET=0 gives target=PC+4 and still pulses FLUSH.
// STRUCTURE
//   Shared include pc_unit_defs.vh holds:
//     state encodings RUN=2'd0, STALL=2'd1, STALL_PEND=2'd2; 2'd3 is illegal and recovers to RUN
//     the PC increment constant 4
//   Sub-module branch_target_adder(pc_plus4, offset, target):
//     combinational sign-extend, shift left 2, add. Reused by the jump path.
//   Top: FSM register, PC register, pend_target register, FLUSH register, stall counter.
// TESTING
//   RESET=1 for 2 edges, then free-run with no stall -> PC=0,4,8,12, FLUSH=0, STALL_CNT=0.
//   At PC=8, BRANCH_TAKEN=1 and OFFSET=8'hFE -> next PC=4, FLUSH=1 for one cycle, then PC=8.
//   BUSYWAIT_I=1 for 3 cycles at PC=12 with no redirect -> PC holds 12 for 3 cycles, then 16. STALL_CNT=3.
//   At PC=16: JUMP=1, OFFSET=8'h03, BUSYWAIT_D=1 on the same edge, busywait for 2 cycles,
//     then JUMP/OFFSET changed to junk -> PC=32 after busywait drops, FLUSH=1 once.
//   RESET asserted while in STALL_PEND -> PC=0, FLUSH=0, STALL_CNT=0. Pending target never applied.
//   Force STALL_CNT to 16'hFFFE and hold the stall 5 cycles -> STALL_CNT=16'hFFFF and stays there.
//   PC=32'hFFFFFFFC with no redirect -> PC wraps to 0.

Source files
------------

// File: rtl/pc_update_unit_pkg.sv
// rtl/pc_update_unit_pkg.sv - shared state encodings and constants for the PC update stage
package pc_update_unit_pkg;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_STALL      = 2'd1,
        ST_STALL_PEND = 2'd2
    } pc_state_e;

    localparam int unsigned PC_INC = 4;

    function automatic logic any_busy(input logic busy_i, input logic busy_d);
        return busy_i | busy_d;
    endfunction

endpackage

// File: rtl/branch_target_adder.sv
// rtl/branch_target_adder.sv - PC-relative target: pc_plus4 + (sext(offset) << 2)
module branch_target_adder #(
    parameter int PC_W  = 32,
    parameter int OFF_W = 8
) (
    input  logic [PC_W-1:0]  pc_plus4,
    input  logic [OFF_W-1:0] offset,
    output logic [PC_W-1:0]  target
);

    logic [PC_W-1:0] off_ext;

    // Offset counts instructions, so scale to bytes; overflow wraps silently.
    assign off_ext = {{(PC_W-OFF_W){offset[OFF_W-1]}}, offset};
    assign target  = pc_plus4 + (off_ext << 2);

endmodule

// File: rtl/pc_update_unit.sv
// rtl/pc_update_unit.sv - program counter with stall hold, pending redirect and flush pulse
module pc_update_unit
    import pc_update_unit_pkg::*;
#(
    parameter int           PC_W     = 32,
    parameter int           OFF_W    = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int           CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             BRANCH_TAKEN,
    input  logic             JUMP,
    input  logic [OFF_W-1:0] OFFSET,
    input  logic             BUSYWAIT_I,
    input  logic             BUSYWAIT_D,
    output logic [PC_W-1:0]  PC,
    output logic [PC_W-1:0]  PC_PLUS4,
    output logic             FLUSH,
    output logic [CNT_W-1:0] STALL_CNT
);

    pc_state_e        state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  pend_q, pend_d;
    logic             flush_q, flush_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [PC_W-1:0]  pc_plus4;
    logic [PC_W-1:0]  target;
    logic             stall;
    logic             redirect;

    assign pc_plus4 = pc_q + PC_W'(PC_INC);
    assign stall    = any_busy(BUSYWAIT_I, BUSYWAIT_D);
    assign redirect = BRANCH_TAKEN | JUMP;

    branch_target_adder #(
        .PC_W  (PC_W),
        .OFF_W (OFF_W)
    ) u_target (
        .pc_plus4 (pc_plus4),
        .offset   (OFFSET),
        .target   (target)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        flush_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (stall && redirect) begin
                    pend_d  = target;
                    state_d = ST_STALL_PEND;
                end else if (stall) begin
                    state_d = ST_STALL;
                end else if (redirect) begin
                    pc_d    = target;
                    flush_d = 1'b1;
                end else begin
                    pc_d = pc_plus4;
                end
            end
            // The stalled instruction is frozen in decode; any redirect it shows is stale.
            ST_STALL: begin
                if (!stall) begin
                    pc_d    = pc_plus4;
                    state_d = ST_RUN;
                end
            end
            ST_STALL_PEND: begin
                if (!stall) begin
                    pc_d    = pend_q;
                    flush_d = 1'b1;
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            pend_q  <= '0;
            flush_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            flush_q <= flush_d;
            cnt_q   <= cnt_d;
        end
    end

    assign PC        = pc_q;
    assign PC_PLUS4  = pc_plus4;
    assign FLUSH     = flush_q;
    assign STALL_CNT = cnt_q;

endmodule

// File: tb/tb_pc_update_unit.sv
// tb/tb_pc_update_unit.sv - directed self-checking bench for pc_update_unit
module tb_pc_update_unit;

    logic        clk;
    logic        reset, branch, jump, bw_i, bw_d;
    logic [7:0]  offset;
    logic [31:0] pc, pc_plus4;
    logic        flush;
    logic [15:0] stall_cnt;

    logic        b_reset, b_branch, b_jump, b_bw_i, b_bw_d;
    logic [7:0]  b_offset;
    logic [31:0] b_pc, b_pc_plus4;
    logic        b_flush;
    logic [3:0]  b_stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    pc_update_unit dut (
        .CLK          (clk),
        .RESET        (reset),
        .BRANCH_TAKEN (branch),
        .JUMP         (jump),
        .OFFSET       (offset),
        .BUSYWAIT_I   (bw_i),
        .BUSYWAIT_D   (bw_d),
        .PC           (pc),
        .PC_PLUS4     (pc_plus4),
        .FLUSH        (flush),
        .STALL_CNT    (stall_cnt)
    );

    pc_update_unit #(
        .RESET_PC (32'hFFFF_FFF8),
        .CNT_W    (4)
    ) dut_b (
        .CLK          (clk),
        .RESET        (b_reset),
        .BRANCH_TAKEN (b_branch),
        .JUMP         (b_jump),
        .OFFSET       (b_offset),
        .BUSYWAIT_I   (b_bw_i),
        .BUSYWAIT_D   (b_bw_d),
        .PC           (b_pc),
        .PC_PLUS4     (b_pc_plus4),
        .FLUSH        (b_flush),
        .STALL_CNT    (b_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_main(input string tag, input logic [31:0] e_pc,
                               input logic e_flush, input logic [15:0] e_cnt);
        check({tag, ".pc"}, pc, e_pc);
        check({tag, ".flush"}, {31'd0, flush}, {31'd0, e_flush});
        check({tag, ".cnt"}, {16'd0, stall_cnt}, {16'd0, e_cnt});
    endtask

    initial begin
        reset = 1'b1; branch = 1'b0; jump = 1'b0; offset = 8'h00; bw_i = 1'b0; bw_d = 1'b0;
        b_reset = 1'b1; b_branch = 1'b0; b_jump = 1'b0; b_offset = 8'h00; b_bw_i = 1'b0; b_bw_d = 1'b0;

        // Reset held two edges, with a redirect asserted to show reset wins.
        branch = 1'b1; offset = 8'h10; bw_i = 1'b1;
        tick(2);
        expect_main("reset", 32'd0, 1'b0, 16'd0);
        check("reset.plus4", pc_plus4, 32'd4);
        branch = 1'b0; offset = 8'h00; bw_i = 1'b0;
        reset = 1'b0;

        tick(); expect_main("run1", 32'd4, 1'b0, 16'd0);
        tick(); expect_main("run2", 32'd8, 1'b0, 16'd0);

        // Backward branch: 12 + (-2 << 2) = 4
        branch = 1'b1; offset = 8'hFE;
        tick(); expect_main("br_taken", 32'd4, 1'b1, 16'd0);
        branch = 1'b0; offset = 8'h00;
        tick(); expect_main("br_after", 32'd8, 1'b0, 16'd0);
        tick(); expect_main("run3", 32'd12, 1'b0, 16'd0);

        bw_i = 1'b1;
        tick(); expect_main("istall1", 32'd12, 1'b0, 16'd1);
        tick(); expect_main("istall2", 32'd12, 1'b0, 16'd2);
        tick(); expect_main("istall3", 32'd12, 1'b0, 16'd3);
        bw_i = 1'b0;
        tick(); expect_main("istall_exit", 32'd16, 1'b0, 16'd3);

        // Jump during D-stall: target 20 + 12 = 32 latched, later inputs are junk.
        jump = 1'b1; offset = 8'h03; bw_d = 1'b1;
        tick(); expect_main("pend1", 32'd16, 1'b0, 16'd4);
        jump = 1'b0; branch = 1'b1; offset = 8'h80;
        tick(); expect_main("pend2", 32'd16, 1'b0, 16'd5);
        bw_d = 1'b0;
        tick(); expect_main("pend_apply", 32'd32, 1'b1, 16'd5);
        branch = 1'b0; offset = 8'h00;
        tick(); expect_main("pend_after", 32'd36, 1'b0, 16'd5);

        // Redirect seen while in plain STALL is ignored.
        bw_i = 1'b1;
        tick(); expect_main("stall_ign1", 32'd36, 1'b0, 16'd6);
        jump = 1'b1; offset = 8'h05;
        tick(); expect_main("stall_ign2", 32'd36, 1'b0, 16'd7);
        bw_i = 1'b0;
        tick(); expect_main("stall_ign_exit", 32'd40, 1'b0, 16'd7);

        // Zero offset still redirects and flushes.
        offset = 8'h00;
        tick(); expect_main("off0", 32'd44, 1'b1, 16'd7);
        jump = 1'b0;

        // Reset while a target is pending discards it.
        bw_d = 1'b1; branch = 1'b1; offset = 8'h10;
        tick(); expect_main("pend_rst_enter", 32'd44, 1'b0, 16'd8);
        reset = 1'b1;
        tick(); expect_main("pend_rst", 32'd0, 1'b0, 16'd0);
        reset = 1'b0; bw_d = 1'b0; branch = 1'b0; offset = 8'h00;
        tick(); expect_main("pend_rst_after", 32'd4, 1'b0, 16'd0);

        // Second instance: PC wrap, target wrap and counter saturation.
        tick();
        check("b.reset_pc", b_pc, 32'hFFFF_FFF8);
        check("b.reset_plus4", b_pc_plus4, 32'hFFFF_FFFC);
        b_reset = 1'b0;
        tick(); check("b.run1", b_pc, 32'hFFFF_FFFC);
        check("b.plus4_wrap", b_pc_plus4, 32'd0);
        tick(); check("b.wrap", b_pc, 32'd0);
        b_branch = 1'b1; b_offset = 8'hFE;
        tick(); check("b.tgt_wrap", b_pc, 32'hFFFF_FFFC);
        check("b.tgt_flush", {31'd0, b_flush}, 32'd1);
        b_branch = 1'b0; b_offset = 8'h00;
        b_bw_d = 1'b1;
        tick(14);
        check("b.cnt14", {28'd0, b_stall_cnt}, 32'd14);
        check("b.hold", b_pc, 32'hFFFF_FFFC);
        tick(); check("b.cnt_max", {28'd0, b_stall_cnt}, 32'd15);
        tick(4); check("b.cnt_sat", {28'd0, b_stall_cnt}, 32'd15);
        b_bw_d = 1'b0;
        tick(); check("b.stall_exit_wrap", b_pc, 32'd0);
        check("b.cnt_final", {28'd0, b_stall_cnt}, 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
